// File: rtl/r22sdf_pkg.sv
// Shared types and helpers for the R2^2 SDF FFT control path.
package r22sdf_pkg;

    // Wide container for local indices and twiddle exponents.
    typedef logic [31:0] r22_idx_t;

    // Twiddle exponent multiplier selected by the top two index bits.
    function automatic logic [1:0] r22_fmap(input logic [1:0] q);
        logic [1:0] f;
        unique case (q)
            2'd0: f = 2'd0;
            2'd1: f = 2'd2;
            2'd2: f = 2'd1;
            default: f = 2'd3;
        endcase
        return f;
    endfunction

    // Local sub-transform length seen by a stage.
    function automatic int r22_local_len(input int log2n, input int stage);
        return 1 << (log2n - 2 * stage);
    endfunction

    // Exponent e = r * f(q) for a kw-bit local index.
    function automatic r22_idx_t r22_tw_exp(input r22_idx_t k, input int kw);
        r22_idx_t q;
        r22_idx_t r;
        r22_idx_t mask;
        mask = (r22_idx_t'(1) << (kw - 2)) - r22_idx_t'(1);
        q    = (k >> (kw - 2)) & r22_idx_t'(3);
        r    = k & mask;
        return r * r22_idx_t'(r22_fmap(q[1:0]));
    endfunction

endpackage

// File: rtl/r22sdf_stage_counter.sv
// Local index counter for one R2^2 stage with sop resync and sync error detection.
module r22sdf_stage_counter #(
    parameter int KW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sop,
    output logic [KW-1:0] idx,
    output logic          resync_err
);

    logic [KW-1:0] k_q, k_d;

    always_comb begin
        // A qualified sop forces the current sample to index 0.
        idx        = (in_valid && in_sop) ? '0 : k_q;
        resync_err = in_valid && in_sop && (k_q != '0);
        k_d        = k_q;
        if (in_valid) k_d = idx + KW'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) k_q <= '0;
        else        k_q <= k_d;
    end

endmodule

// File: rtl/r22sdf_twiddle_ctrl.sv
// Twiddle address and butterfly select generator for one R2^2 SDF stage.
module r22sdf_twiddle_ctrl
    import r22sdf_pkg::*;
#(
    parameter int LOG2N = 8,
    parameter int STAGE = 0,
    parameter int AW    = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sop,
    output logic          out_valid,
    output logic          out_sop,
    output logic          out_eop,
    output logic          bf1_sel,
    output logic          bf2_sel,
    output logic [AW-1:0] tw_addr,
    output logic          tw_trivial,
    output logic          sync_err
);

    localparam int KW = LOG2N - 2 * STAGE;
    localparam int M  = r22_local_len(LOG2N, STAGE);

    if ((LOG2N % 2) != 0) begin : g_bad_log2n
        $fatal(1, "r22sdf_twiddle_ctrl: LOG2N must be even");
    end
    if (AW != LOG2N) begin : g_bad_aw
        $fatal(1, "r22sdf_twiddle_ctrl: AW must equal LOG2N");
    end
    if (KW < 2) begin : g_bad_stage
        $fatal(1, "r22sdf_twiddle_ctrl: LOG2N-2*STAGE must be >= 2");
    end

    logic [KW-1:0] idx;
    logic          resync_err;
    r22_idx_t      tw_exp;
    r22_idx_t      tw_full;

    r22sdf_stage_counter #(
        .KW(KW)
    ) u_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_sop     (in_sop),
        .idx        (idx),
        .resync_err (resync_err)
    );

    always_comb begin
        tw_exp  = r22_tw_exp(r22_idx_t'(idx), KW);
        // Stage s sees only every 4^s-th coefficient of the full-length ROM.
        tw_full = tw_exp << (2 * STAGE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_sop    <= 1'b0;
            out_eop    <= 1'b0;
            bf1_sel    <= 1'b0;
            bf2_sel    <= 1'b0;
            tw_addr    <= '0;
            tw_trivial <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            out_valid <= in_valid;
            sync_err  <= resync_err;
            if (in_valid) begin
                out_sop    <= (idx == '0);
                out_eop    <= (idx == KW'(M - 1));
                bf1_sel    <= idx[KW-1];
                bf2_sel    <= idx[KW-2];
                tw_addr    <= tw_full[AW-1:0];
                tw_trivial <= (tw_exp == '0);
            end
        end
    end

endmodule

// File: tb/tb_r22sdf_twiddle_ctrl.sv
// Directed bench for r22sdf_twiddle_ctrl across three stage configurations.
module tb_r22sdf_twiddle_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic in_valid;
    logic in_sop;

    logic       a_valid, a_sop, a_eop, a_bf1, a_bf2, a_triv, a_err;
    logic [3:0] a_tw;
    logic       b_valid, b_sop, b_eop, b_bf1, b_bf2, b_triv, b_err;
    logic [5:0] b_tw;
    logic       c_valid, c_sop, c_eop, c_bf1, c_bf2, c_triv, c_err;
    logic [3:0] c_tw;

    int errors = 0;
    int checks = 0;

    // Hand-computed expectations for LOG2N=4, STAGE=0, k = 0..15.
    logic [3:0] tab_tw   [16] = '{0, 0, 0, 0, 0, 2, 4, 6, 0, 1, 2, 3, 0, 3, 6, 9};
    logic       tab_triv [16] = '{1, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};

    always #5 clk = ~clk;

    r22sdf_twiddle_ctrl #(.LOG2N(4), .STAGE(0), .AW(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
        .out_valid(a_valid), .out_sop(a_sop), .out_eop(a_eop), .bf1_sel(a_bf1),
        .bf2_sel(a_bf2), .tw_addr(a_tw), .tw_trivial(a_triv), .sync_err(a_err)
    );

    r22sdf_twiddle_ctrl #(.LOG2N(6), .STAGE(1), .AW(6)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
        .out_valid(b_valid), .out_sop(b_sop), .out_eop(b_eop), .bf1_sel(b_bf1),
        .bf2_sel(b_bf2), .tw_addr(b_tw), .tw_trivial(b_triv), .sync_err(b_err)
    );

    r22sdf_twiddle_ctrl #(.LOG2N(4), .STAGE(1), .AW(4)) dut_c (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sop(in_sop),
        .out_valid(c_valid), .out_sop(c_sop), .out_eop(c_eop), .bf1_sel(c_bf1),
        .bf2_sel(c_bf2), .tw_addr(c_tw), .tw_trivial(c_triv), .sync_err(c_err)
    );

    // Present one input cycle; outputs for it are visible on return.
    task automatic drive(input logic v, input logic s);
        in_valid = v;
        in_sop   = s;
        @(posedge clk);
        #1;
    endtask

    // Packed view of dut_a: {valid, sop, eop, bf1, bf2, triv, err, tw[3:0]}.
    function automatic logic [10:0] a_vec();
        return {a_valid, a_sop, a_eop, a_bf1, a_bf2, a_triv, a_err, a_tw};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b1, 1'b1);
        drive(1'b1, 1'b1);
        checks++;
        if (a_vec() !== 11'd0) begin
            errors++;
            $display("FAIL reset_a: got %b expected %b", a_vec(), 11'd0);
        end
        checks++;
        if ({b_valid, b_sop, b_tw, b_err, c_valid, c_sop, c_tw, c_err} !== 16'd0) begin
            errors++;
            $display("FAIL reset_bc: got %h expected 0",
                     {b_valid, b_sop, b_tw, b_err, c_valid, c_sop, c_tw, c_err});
        end
        rst_n = 1'b1;
        drive(1'b0, 1'b0);
    endtask

    task automatic test_frame();
        logic [10:0] exp_a;
        logic [3:0]  kb;
        for (int n = 0; n < 16; n++) begin
            kb = 4'(n);
            drive(1'b1, n == 0);
            exp_a = {1'b1, n == 0, n == 15, kb[3], kb[2], tab_triv[n], 1'b0, tab_tw[n]};
            checks++;
            if (a_vec() !== exp_a) begin
                errors++;
                $display("FAIL frame_a k=%0d: got %b expected %b", n, a_vec(), exp_a);
            end
            if (n == 7 || n == 13 || n == 15) begin
                checks++;
                if (b_tw !== ((n == 7) ? 6'd24 : (n == 13) ? 6'd12 : 6'd36)) begin
                    errors++;
                    $display("FAIL stage1_b k=%0d: got %0d", n, b_tw);
                end
            end
            checks++;
            if ({c_valid, c_tw, c_triv, c_bf1, c_bf2} !== {1'b1, 4'd0, 1'b1, kb[1], kb[0]}) begin
                errors++;
                $display("FAIL m4_c k=%0d: got %b expected %b", n,
                         {c_valid, c_tw, c_triv, c_bf1, c_bf2},
                         {1'b1, 4'd0, 1'b1, kb[1], kb[0]});
            end
        end
        checks++;
        if ({b_eop, c_eop} !== 2'b11) begin
            errors++;
            $display("FAIL eop_bc: got %b expected 11", {b_eop, c_eop});
        end
    endtask

    task automatic test_gaps();
        logic [10:0] prev;
        logic [10:0] exp_a;
        logic [3:0]  kb;
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 16; n++) begin
                kb = 4'(n);
                prev = a_vec();
                repeat ($urandom_range(0, 2)) begin
                    drive(1'b0, 1'b1);
                    checks++;
                    if (a_vec() !== {1'b0, prev[9:5], 1'b0, prev[3:0]}) begin
                        errors++;
                        $display("FAIL gap_hold f=%0d k=%0d: got %b expected %b", f, n,
                                 a_vec(), {1'b0, prev[9:5], 1'b0, prev[3:0]});
                    end
                end
                drive(1'b1, n == 0);
                exp_a = {1'b1, n == 0, n == 15, kb[3], kb[2], tab_triv[n], 1'b0, tab_tw[n]};
                checks++;
                if (a_vec() !== exp_a) begin
                    errors++;
                    $display("FAIL gap_seq f=%0d k=%0d: got %b expected %b", f, n,
                             a_vec(), exp_a);
                end
            end
        end
    endtask

    task automatic test_sync_err();
        drive(1'b1, 1'b1);
        for (int n = 1; n < 5; n++) drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        checks++;
        if ({a_err, a_sop, a_tw, a_triv} !== {1'b1, 1'b1, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL sync_err_pulse: got %b expected %b",
                     {a_err, a_sop, a_tw, a_triv}, {1'b1, 1'b1, 4'd0, 1'b1});
        end
        drive(1'b1, 1'b0);
        checks++;
        if ({a_err, a_sop, a_bf1, a_bf2} !== 4'b0000) begin
            errors++;
            $display("FAIL sync_err_after: got %b expected 0000", {a_err, a_sop, a_bf1, a_bf2});
        end
        for (int n = 2; n < 6; n++) drive(1'b1, 1'b0);
        checks++;
        if ({a_tw, a_bf2} !== {4'd2, 1'b1}) begin
            errors++;
            $display("FAIL resync_k5: got %b expected %b", {a_tw, a_bf2}, {4'd2, 1'b1});
        end
    endtask

    task automatic test_reset_mid();
        drive(1'b1, 1'b1);
        for (int n = 1; n < 9; n++) drive(1'b1, 1'b0);
        rst_n = 1'b0;
        drive(1'b1, 1'b0);
        checks++;
        if (a_vec() !== 11'd0) begin
            errors++;
            $display("FAIL reset_mid: got %b expected %b", a_vec(), 11'd0);
        end
        rst_n = 1'b1;
        drive(1'b1, 1'b0);
        checks++;
        if (a_vec() !== {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL reset_resume: got %b expected %b", a_vec(),
                     {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0});
        end
        for (int n = 1; n < 6; n++) drive(1'b1, 1'b0);
        checks++;
        if ({a_sop, a_tw} !== {1'b0, 4'd2}) begin
            errors++;
            $display("FAIL reset_k5: got %b expected %b", {a_sop, a_tw}, {1'b0, 4'd2});
        end
    endtask

    initial begin
        in_valid = 1'b0;
        in_sop   = 1'b0;
        rst_n    = 1'b0;
        test_reset();
        test_frame();
        test_gaps();
        test_sync_err();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/r22sdf_twiddle_ctrl.md
R22SDF_TWIDDLE_CTRL -- requirements
Module: r22sdf_twiddle_ctrl

Interface
REQ-001 SHALL have parameter LOG2N, default 8, log2 of the FFT length N; even, >= 2.
REQ-002 SHALL have parameter STAGE, default 0, R2^2 stage index; LOG2N-2*STAGE >= 2.
REQ-003 SHALL have parameter AW, default 8, coefficient ROM address width; equals LOG2N.
REQ-004 SHALL have port clk  in  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, synchronous and active-low.
REQ-006 SHALL have port in_valid  in  1  a sample is presented to the stage this cycle.
REQ-007 SHALL have port in_sop  in  1  the sample is the first of a frame; qualified by in_valid.
REQ-008 SHALL have port out_valid  out  1  the control outputs below apply to this cycle's stage sample.
REQ-009 SHALL have port out_sop / out_eop  out  1 each  local index k = 0 / k = M-1.
REQ-010 SHALL have port bf1_sel  out  1  BF2I butterfly select.
REQ-011 SHALL have port bf2_sel  out  1  BF2II butterfly select.
REQ-012 SHALL have port tw_addr  out  AW  coefficient ROM address.
REQ-013 SHALL have port tw_trivial  out  1  the twiddle is W^0; the multiplier may bypass.
REQ-014 SHALL have port sync_err  out  1  one-cycle pulse when in_sop is accepted with k != 0.

Function
REQ-015 SHALL keep a local index counter k of width LOG2N-2*STAGE, where M = 2^(LOG2N-2*STAGE).
REQ-016 SHALL advance k only on cycles with in_valid=1 and wrap from M-1 to 0; gaps in in_valid freeze all state.
REQ-017 SHALL treat in_valid=1 with in_sop=1 as index 0, then set k to 1 for the next sample; in_sop with in_valid=0 is ignored.
REQ-018 SHALL pulse sync_err on the output cycle of an in_sop accepted while k != 0; the resync still takes effect.
REQ-019 SHALL register all outputs with exactly 1 cycle of latency from the accepted input cycle; out_valid = in_valid delayed by 1.
REQ-020 SHALL set bf1_sel = k[MSB] and bf2_sel = k[MSB-1].
REQ-021 SHALL split k as q = k[MSB:MSB-1] and r = k[MSB-2:0], and form the exponent e = r*f(q) with f(0)=0, f(1)=2, f(2)=1, f(3)=3.
REQ-022 SHALL output tw_addr = e * 4^STAGE, truncated to AW bits; e <= 3*(M/4-1) < M, so the result never overflows.
REQ-023 SHALL drive tw_trivial=1 exactly when e=0; when M=4, e=0 and tw_addr=0 for every sample.
REQ-024 SHALL hold tw_addr, tw_trivial, bf1_sel, bf2_sel, out_sop and out_eop at their last values when out_valid=0.
REQ-025 SHALL make tw_addr directly usable by a combinational ROM indexed by W_N^a, so the coefficient is aligned with out_valid.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, set k=0 and drive all outputs to 0, including out_valid and sync_err.
REQ-027 SHALL, on reset asserted mid-frame, abandon the frame; the first accepted sample after release is index 0 whether or not in_sop=1.

Structure
REQ-028 SHALL place the f(q) mapping function, the R2^2 local-length function M(LOG2N, STAGE) and the index typedef in the shared package r22sdf_pkg.
REQ-029 SHALL use one sub-module, r22sdf_stage_counter, containing k, the wrap and sop-resync logic and the sync_err detection.
REQ-030 SHALL check parameter legality at elaboration (LOG2N even, AW == LOG2N, LOG2N-2*STAGE >= 2) and fail with a fatal error otherwise.

Verification
REQ-031 SHALL check LOG2N=4, STAGE=0, 16 continuous valids with sop on the first: tw_addr = 0,0,0,0, 0,2,4,6, 0,1,2,3, 0,3,6,9; tw_trivial=1 at k=0-4, 8 and 12 only; out_eop at k=15.
REQ-032 SHALL check LOG2N=6, STAGE=1 (M=16): k=7 gives tw_addr=24, k=15 gives 36, k=13 gives 12.
REQ-033 SHALL check LOG2N=4, STAGE=1 (M=4): every tw_addr=0 and tw_trivial=1; bf1_sel/bf2_sel sequence 00,01,10,11 repeating.
REQ-034 SHALL check random in_valid gaps (~50% duty) over 3 frames: the output sequence equals the gap-free sequence, and out_valid tracks in_valid with 1 cycle of delay.
REQ-035 SHALL check in_sop injected at k=5: sync_err pulses once and out_sop=1 with tw_addr=0; the following sample is k=1.
REQ-036 SHALL check rst_n low for 1 cycle at k=9: all outputs are 0, and the next accepted sample without sop yields out_sop=1 and k=0.
